// File: rtl/virtual_input_pkg.sv
// -----------------------------------------------------------------------------
// virtual_input_pkg
// Shared definitions for the virtual input sequencer: sequencer state
// encoding, decoder special codes and the command-byte decode helpers.
// -----------------------------------------------------------------------------
package virtual_input_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_GAP   = 2'd3
    } seq_state_t;

    // Decoder code that resets every virtual key and switch.
    localparam logic [4:0] NUM_RESET_ALL  = 5'b11111;
    // Highest index that toggles a single virtual input.
    localparam logic [4:0] MAX_TOGGLE_IDX = 5'd21;
    // Required value of the opcode field in_data[7:5].
    localparam logic [2:0] OPCODE_MASK    = 3'b000;

    function automatic logic cmd_is_valid(input logic [7:0] b);
        return (b[7:5] == OPCODE_MASK);
    endfunction

    // Indices past the last real input are folded onto the reset-all code.
    function automatic logic [4:0] cmd_to_number(input logic [7:0] b);
        return (b[4:0] > MAX_TOGGLE_IDX) ? NUM_RESET_ALL : b[4:0];
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// -----------------------------------------------------------------------------
// cmd_fifo
// Small synchronous FIFO for decoded sequencer commands.
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   push, din      write din when not full (ignored while flushing)
//   pop            drop the head entry when not empty (ignored while flushing)
//   flush          empty the FIFO on this edge
//   head           current head entry (valid when !empty)
//   full, empty    status from the registered count
//   count          number of stored entries
// -----------------------------------------------------------------------------
module cmd_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_push;
    logic w_pop;

    assign w_push = push & ~full  & ~flush;
    assign w_pop  = pop  & ~empty & ~flush;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the count alone.
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

    assign head  = r_mem[r_rd_ptr];
    assign full  = (r_count == (PTR_W+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule

// File: rtl/virtual_input_sequencer.sv
// -----------------------------------------------------------------------------
// virtual_input_sequencer
// Buffers host command bytes and replays each as a setup / strobe / gap
// sequence on (number, control) so the virtual input decoder sees exactly one
// toggle per command. clear_all bypasses the queue with the reset-all code.
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   in_data, in_valid     host command byte and its valid
//   in_ready              byte accepted when in_valid & in_ready (FIFO not full)
//   clear_all             one-cycle request to reset all virtual inputs
//   number, control       decoder index and level strobe (registered)
//   busy                  sequence active or commands queued (registered)
//   cmd_error             one-cycle pulse after a malformed byte is dropped
// -----------------------------------------------------------------------------
module virtual_input_sequencer
    import virtual_input_pkg::*;
#(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       clear_all,
    output logic [4:0] number,
    output logic       control,
    output logic       busy,
    output logic       cmd_error
);

    localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int FCNT_W  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

    seq_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [4:0]        r_number;
    logic              r_control;
    logic              r_busy;
    logic              r_clr_pend;
    logic              r_cmd_error;

    logic              w_take;
    logic              w_push;
    logic              w_bad;
    logic              w_pop;
    logic [4:0]        w_head;
    logic              w_full;
    logic              w_empty;
    logic [FCNT_W-1:0] w_count;
    logic [FCNT_W-1:0] w_count_nxt;

    // A byte offered on the same edge as clear_all is dropped: flush wins.
    assign w_take = in_valid & in_ready;
    assign w_push = w_take & ~clear_all &  cmd_is_valid(in_data);
    assign w_bad  = w_take & ~clear_all & ~cmd_is_valid(in_data);

    // Never pop while a clear is pending or arriving; the queue is about to
    // be flushed and the reset-all code must go out first.
    assign w_pop  = (r_state == ST_IDLE) & ~r_clr_pend & ~w_empty & ~clear_all;

    assign in_ready = ~w_full;

    cmd_fifo #(
        .WIDTH (5),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .flush (clear_all),
        .din   (cmd_to_number(in_data)),
        .head  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // FIFO occupancy after this edge, so busy can be registered alongside it.
    always_comb begin
        w_count_nxt = w_count;
        if (clear_all) begin
            w_count_nxt = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = w_count + 1'b1;
                2'b01:   w_count_nxt = w_count - 1'b1;
                default: w_count_nxt = w_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_number   <= 5'b00000;
            r_control  <= 1'b0;
            r_busy     <= 1'b0;
            r_clr_pend <= 1'b0;
        end else begin
            if (clear_all) r_clr_pend <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (r_clr_pend) begin
                        r_number   <= NUM_RESET_ALL;
                        r_clr_pend <= clear_all;
                        r_state    <= ST_SETUP;
                        r_busy     <= 1'b1;
                    end else if (w_pop) begin
                        r_number   <= w_head;
                        r_state    <= ST_SETUP;
                        r_busy     <= 1'b1;
                    end else begin
                        r_busy     <= (w_count_nxt != '0);
                    end
                end
                ST_SETUP: begin
                    r_state   <= ST_PULSE;
                    r_control <= 1'b1;
                    r_cnt     <= PULSE_LAST;
                    r_busy    <= 1'b1;
                end
                ST_PULSE: begin
                    r_busy <= 1'b1;
                    if (r_cnt == '0) begin
                        r_state   <= ST_GAP;
                        r_control <= 1'b0;
                        r_cnt     <= GAP_LAST;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= (w_count_nxt != '0);
                    end else begin
                        r_cnt  <= r_cnt - 1'b1;
                        r_busy <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) r_cmd_error <= 1'b0;
        else       r_cmd_error <= w_bad;
    end

    assign number    = r_number;
    assign control   = r_control;
    assign busy      = r_busy;
    assign cmd_error = r_cmd_error;

endmodule

// File: tb/tb_virtual_input_sequencer.sv
// -----------------------------------------------------------------------------
// tb_virtual_input_sequencer
// Directed scenarios followed by random traffic; every cycle the DUT outputs
// are compared with a queue-and-timer reference model of the sequencer.
// -----------------------------------------------------------------------------
module tb_virtual_input_sequencer;

    localparam int P     = 4;
    localparam int G     = 4;
    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       clear_all;
    logic [4:0] number;
    logic       control;
    logic       busy;
    logic       cmd_error;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    virtual_input_sequencer #(
        .PULSE_CYCLES (P),
        .GAP_CYCLES   (G),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .clear_all (clear_all),
        .number    (number),
        .control   (control),
        .busy      (busy),
        .cmd_error (cmd_error)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a command queue, a pending-clear flag and the age of the
    // current sequence in cycles (-1 when idle). Age 0 is the setup cycle,
    // 1..P the strobe, P+1..P+G the gap.
    logic [4:0] m_q[$];
    bit         m_pend    = 0;
    int         m_age     = -1;
    logic [4:0] m_num     = 0;
    bit         m_err     = 0;
    bit         m_started = 0;

    always @(posedge clock) begin
        if (reset) begin
            m_q.delete();
            m_pend = 0;
            m_age  = -1;
            m_num  = 0;
            m_err  = 0;
        end else begin
            bit take;
            bit ok;
            take  = in_valid && (m_q.size() < DEPTH);
            ok    = (in_data[7:5] == 3'b000);
            m_err = take && !clear_all && !ok;
            if (m_age < 0) begin
                if (m_pend) begin
                    m_num  = 5'd31;
                    m_pend = 0;
                    m_age  = 0;
                end else if (m_q.size() > 0 && !clear_all) begin
                    m_num = m_q.pop_front();
                    m_age = 0;
                end
            end else begin
                m_age++;
                if (m_age > P + G) m_age = -1;
            end
            if (clear_all) begin
                m_pend = 1;
                m_q.delete();
            end else if (take && ok) begin
                m_q.push_back((in_data[4:0] <= 21) ? in_data[4:0] : 5'd31);
            end
        end
        m_started = 1;
    end

    always @(negedge clock) begin
        if (m_started) begin
            check("number",    number,    m_num);
            check("control",   control,   (m_age >= 1 && m_age <= P));
            check("busy",      busy,      (m_age >= 0 || m_q.size() != 0));
            check("cmd_error", cmd_error, m_err);
            check("in_ready",  in_ready,  (m_q.size() < DEPTH));
        end
    end

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send(input logic [7:0] b);
        int w = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && w < 200) begin
            @(negedge clock);
            w++;
        end
        check("send_ready", in_ready, 1);
        @(negedge clock);
    endtask

    task automatic quiet(input int n);
        in_valid  = 1'b0;
        clear_all = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_control();
        int w = 0;
        while (!control && w < 40) begin
            @(negedge clock);
            w++;
        end
        check("wait_control", control, 1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        clear_all = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_number",  number,    0);
        check("rst_control", control,   0);
        check("rst_busy",    busy,      0);
        check("rst_error",   cmd_error, 0);
        reset = 1'b0;
        @(negedge clock);
        check("rst_ready", in_ready, 1);

        // Single command
        send(8'h05);
        quiet(14);

        // Queue fill: five bytes back to back
        for (int i = 0; i < 5; i++) send(8'(i));
        quiet(60);

        // Decode: reset-all alias and malformed byte
        send(8'h1A);
        quiet(12);
        send(8'h45);
        quiet(12);

        // Clear during a strobe with a command queued
        send(8'h03);
        send(8'h07);
        in_valid = 1'b0;
        wait_control();
        @(negedge clock);
        clear_all = 1'b1;
        @(negedge clock);
        quiet(30);

        // Clear and a byte on the same edge
        clear_all = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h02;
        @(negedge clock);
        quiet(15);

        // Reset in the third strobe cycle with a command queued
        send(8'h05);
        send(8'h06);
        in_valid = 1'b0;
        wait_control();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("ready_after_mid_rst", in_ready, 1);
        quiet(15);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31));
            clear_all = ($urandom_range(0, 63) == 0);
            reset     = ($urandom_range(0, 799) == 0);
            @(negedge clock);
        end
        reset = 1'b0;
        quiet(30);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
